// File: rtl/wb_pipe_unit_pkg.sv
// rtl/wb_pipe_unit_pkg.sv - shared encodings for the write-back stage
package wb_pipe_unit_pkg;

    typedef enum logic [1:0] {
        SEL_ALU_AS_RES       = 2'd0,
        SEL_MEM_AS_RES       = 2'd1,
        SEL_PC_PLUS_4_AS_RES = 2'd2,
        SEL_CSR_AS_RES       = 2'd3
    } result_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        WB_EMPTY     = 2'd0,
        WB_READY     = 2'd1,
        WB_WAIT_LOAD = 2'd2
    } wb_state_e;

    function automatic logic is_load(input logic [1:0] sel);
        return sel == SEL_MEM_AS_RES;
    endfunction

endpackage

// File: rtl/wb_pipe_unit_if.sv
// rtl/wb_pipe_unit_if.sv - MEM/WB, data-memory response and register-file bundle
interface wb_pipe_unit_if #(
    parameter int INST_WIDTH          = 32,
    parameter int INST_ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int INSTRET_WIDTH       = 64
);
    logic                           valid_MEM_WB_i;
    logic [INST_WIDTH-1:0]          INST_MEM_WB_i;
    logic                           reg_write_MEM_WB_i;
    logic [1:0]                     result_sel_MEM_WB_i;
    logic [DATA_WIDTH-1:0]          alu_res_MEM_WB_i;
    logic [DATA_WIDTH-1:0]          csr_rdata_MEM_WB_i;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM_WB_i;
    logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_MEM_WB_i;
    logic                           flush_WB;
    logic                           dmem_rvalid;
    logic [DATA_WIDTH-1:0]          dmem_rdata;

    logic                           stall_WB;
    logic [INST_WIDTH-1:0]          INST_WB;
    logic                           reg_write_WB;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_WB;
    logic [DATA_WIDTH-1:0]          result_WB;
    logic                           retire_WB;
    logic [INSTRET_WIDTH-1:0]       instret_WB;

    modport master (
        output valid_MEM_WB_i, INST_MEM_WB_i, reg_write_MEM_WB_i, result_sel_MEM_WB_i,
               alu_res_MEM_WB_i, csr_rdata_MEM_WB_i, rd_MEM_WB_i, PC_plus_4_MEM_WB_i,
               flush_WB, dmem_rvalid, dmem_rdata,
        input  stall_WB, INST_WB, reg_write_WB, rd_WB, result_WB, retire_WB, instret_WB
    );

    modport slave (
        input  valid_MEM_WB_i, INST_MEM_WB_i, reg_write_MEM_WB_i, result_sel_MEM_WB_i,
               alu_res_MEM_WB_i, csr_rdata_MEM_WB_i, rd_MEM_WB_i, PC_plus_4_MEM_WB_i,
               flush_WB, dmem_rvalid, dmem_rdata,
        output stall_WB, INST_WB, reg_write_WB, rd_WB, result_WB, retire_WB, instret_WB
    );
endinterface

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - selects and sign/zero-extends load data from a raw memory word
module wb_load_align
    import wb_pipe_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]                        funct3_i,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]   offset_i,
    input  logic [DATA_WIDTH-1:0]             raw_i,
    output logic [DATA_WIDTH-1:0]             data_o
);
    localparam int OFF_W = $clog2(DATA_WIDTH/8);

    logic [OFF_W-1:0] half_off;
    logic [OFF_W-1:0] word_off;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;

    // Halfword and word lanes ignore the low offset bits; at 32 bits the word lane is the whole word.
    always_comb begin
        half_off    = offset_i;
        half_off[0] = 1'b0;
        word_off    = offset_i;
        word_off[1:0] = 2'b00;
        byte_v = 8'(raw_i >> {offset_i, 3'b000});
        half_v = 16'(raw_i >> {half_off, 3'b000});
        word_v = 32'(raw_i >> {word_off, 3'b000});
    end

    always_comb begin
        data_o = raw_i;
        case (funct3_i)
            F3_LB: begin
                data_o       = {DATA_WIDTH{byte_v[7]}};
                data_o[7:0]  = byte_v;
            end
            F3_LH: begin
                data_o       = {DATA_WIDTH{half_v[15]}};
                data_o[15:0] = half_v;
            end
            F3_LW: begin
                data_o       = {DATA_WIDTH{word_v[31]}};
                data_o[31:0] = word_v;
            end
            F3_LBU: begin
                data_o       = '0;
                data_o[7:0]  = byte_v;
            end
            F3_LHU: begin
                data_o       = '0;
                data_o[15:0] = half_v;
            end
            F3_LWU: begin
                if (DATA_WIDTH == 64) begin
                    data_o       = '0;
                    data_o[31:0] = word_v;
                end
            end
            F3_LD:   data_o = raw_i;
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/wb_pipe_unit.sv
// rtl/wb_pipe_unit.sv - write-back stage: MEM/WB register, load wait, result mux, retire counter
module wb_pipe_unit
    import wb_pipe_unit_pkg::*;
#(
    parameter int INST_WIDTH          = 32,
    parameter int INST_ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int INSTRET_WIDTH       = 64
) (
    input  logic         clk,
    input  logic         rst,
    wb_pipe_unit_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_WIDTH/8);

    wb_state_e                      state_q;
    logic [INST_WIDTH-1:0]          inst_q;
    logic                           reg_write_q;
    logic [1:0]                     sel_q;
    logic [DATA_WIDTH-1:0]          alu_q;
    logic [DATA_WIDTH-1:0]          csr_q;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_q;
    logic [INST_ADDR_WIDTH-1:0]     pc_q;
    logic [INSTRET_WIDTH-1:0]       instret_q;
    logic [INSTRET_WIDTH-1:0]       instret_d;

    logic                           stall;
    logic                           commit;
    logic                           retire;
    logic                           capture;
    logic [DATA_WIDTH-1:0]          load_data;
    logic [DATA_WIDTH-1:0]          result;

    assign stall   = (state_q == WB_WAIT_LOAD) && !bus.dmem_rvalid;
    assign commit  = (state_q == WB_READY) || ((state_q == WB_WAIT_LOAD) && bus.dmem_rvalid);
    assign retire  = commit && !bus.flush_WB;
    assign capture = !stall && !bus.flush_WB;
    assign instret_d = retire ? instret_q + INSTRET_WIDTH'(1) : instret_q;

    wb_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .funct3_i (inst_q[14:12]),
        .offset_i (alu_q[OFF_W-1:0]),
        .raw_i    (bus.dmem_rdata),
        .data_o   (load_data)
    );

    always_comb begin
        result = alu_q;
        case (sel_q)
            SEL_ALU_AS_RES:       result = alu_q;
            SEL_MEM_AS_RES:       result = load_data;
            SEL_PC_PLUS_4_AS_RES: result = DATA_WIDTH'(pc_q);
            SEL_CSR_AS_RES:       result = csr_q;
            default:              result = alu_q;
        endcase
    end

    // Flush wins over capture; a stalled load simply holds the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WB_EMPTY;
            inst_q      <= '0;
            reg_write_q <= 1'b0;
            sel_q       <= '0;
            alu_q       <= '0;
            csr_q       <= '0;
            rd_q        <= '0;
            pc_q        <= '0;
            instret_q   <= '0;
        end else begin
            instret_q <= instret_d;
            if (bus.flush_WB) begin
                state_q <= WB_EMPTY;
            end else if (capture) begin
                inst_q      <= bus.INST_MEM_WB_i;
                reg_write_q <= bus.reg_write_MEM_WB_i;
                sel_q       <= bus.result_sel_MEM_WB_i;
                alu_q       <= bus.alu_res_MEM_WB_i;
                csr_q       <= bus.csr_rdata_MEM_WB_i;
                rd_q        <= bus.rd_MEM_WB_i;
                pc_q        <= bus.PC_plus_4_MEM_WB_i;
                if (!bus.valid_MEM_WB_i) begin
                    state_q <= WB_EMPTY;
                end else if (is_load(bus.result_sel_MEM_WB_i)) begin
                    state_q <= WB_WAIT_LOAD;
                end else begin
                    state_q <= WB_READY;
                end
            end
        end
    end

    // Outputs are forced low while reset is asserted so nothing stale leaks out of the reset cycle.
    assign bus.stall_WB     = !rst && stall;
    assign bus.retire_WB    = !rst && retire;
    assign bus.reg_write_WB = !rst && retire && reg_write_q && (rd_q != '0);
    assign bus.INST_WB      = rst ? '0 : inst_q;
    assign bus.rd_WB        = rst ? '0 : rd_q;
    assign bus.result_WB    = rst ? '0 : result;
    assign bus.instret_WB   = rst ? '0 : instret_q;

endmodule
